// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction geometry, fetch FSM states, halt word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INSTR_W  = 8;
    localparam int OPCODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Fetching this word ends the program when halting on zero is enabled.
    localparam logic [INSTR_W-1:0] HALT_WORD = 8'h00;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector.
// Latency: a 0->1 on d_i sampled at edge N gives rise_o high for the cycle after N.
// Backpressure: none; a level held high yields exactly one pulse.
//
// Ports: clk_i clock, rst_ni async active-low reset, d_i level input,
//        rise_o one-cycle registered pulse per rising edge of d_i.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic sampled_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sampled_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sampled_q <= d_i;
            rise_q    <= d_i & ~sampled_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program memory + PC + fetch FSM feeding the CPU instruction register on load_ir rising edges.
// Latency: load_ir rises before edge N -> instruction/instr_valid/pc update at edge N+1.
// Backpressure: none; at most one fetch per load_ir rising edge, extra edges outside RUN dropped.
//
// Ports: clk, reset (async active-low); prog_we/prog_addr/prog_data program write (IDLE/HALT only);
//        start begins at address 0; load_ir fetch request level; pc_load/pc_target jump (RUN only);
//        instruction/instr_valid fetched word and its one-cycle pulse; pc next fetch address;
//        busy (RUN) and halted (HALT) status.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               load_ir,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic               fetch_req;
    logic               fetch;
    logic               halt_hit;
    logic               mem_we;
    logic [INSTR_W-1:0] word;

    rise_detect u_load_ir_rise (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (load_ir),
        .rise_o (fetch_req)
    );

    assign word     = mem_q[pc_q];
    assign fetch    = (state_q == RUN) && fetch_req;
    assign halt_hit = HALT_ON_ZERO && (word == HALT_WORD);
    // The memory is only writable while the program is not executing.
    assign mem_we   = prog_we && (state_q != RUN);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fetch && halt_hit) state_d = HALT;
            HALT:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = fetch;
        if (fetch) begin
            instr_d = word;
        end
        if (state_q == RUN) begin
            if (fetch && !halt_hit) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            // A jump in the same cycle as a fetch wins over the increment;
            // the fetch itself already used the old PC.
            if (pc_load) begin
                pc_d = pc_target;
            end
        end else if (start) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    // Flop-based program store so reset can clear every word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign busy        = (state_q == RUN);
    assign halted      = (state_q == HALT);

endmodule
